// File: rtl/mdac_sched.sv
// mdac_sched: frame scheduler that shares a single 16x16 signed-by-unsigned
// multiplier across three voice-envelope slots and one master-volume slot.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for CLKen; inputs are snapshotted on the accepting edge
//   MUL0  | voice 0 x envelope 0 into the product register
//   MUL1  | voice 1 x envelope 1; AMP0 written from the slot-0 product
//   MUL2  | voice 2 x envelope 2; AMP1 written from the slot-1 product
//   MUL3  | mix x master volume;  AMP2 written from the slot-2 product
//   WB    | MASTER written from the slot-3 product; DONE raised next cycle
module mdac_sched (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        CLKen,
    input  logic [11:0] VOICE0,
    input  logic [11:0] VOICE1,
    input  logic [11:0] VOICE2,
    input  logic [7:0]  ENV0,
    input  logic [7:0]  ENV1,
    input  logic [7:0]  ENV2,
    input  logic [15:0] MIX,
    input  logic [3:0]  VOL,
    output logic [15:0] AMP0,
    output logic [15:0] AMP1,
    output logic [15:0] AMP2,
    output logic [15:0] MASTER,
    output logic        BUSY,
    output logic        DONE,
    output logic        OVERRUN
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL0 = 3'd1,
        MUL1 = 3'd2,
        MUL2 = 3'd3,
        MUL3 = 3'd4,
        WB   = 3'd5
    } state_t;

    state_t state_q, state_d;

    logic [11:0] voice0_q, voice1_q, voice2_q;
    logic [7:0]  env0_q, env1_q, env2_q;
    logic [15:0] mix_q;
    logic [3:0]  vol_q;

    logic [31:0] prod_q, prod_d;
    logic [15:0] amp0_q, amp1_q, amp2_q, master_q;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;

    logic        snap_en;
    logic        mul_en;
    logic        wr_amp0, wr_amp1, wr_amp2, wr_master;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic signed [31:0] mul_a_ext, mul_b_ext;

    // Operand A is signed, operand B is unsigned; both widened to 32 bits so
    // the modulo-2^32 product is exact for the full operand ranges.
    assign mul_a_ext = {{16{mul_a[15]}}, mul_a};
    assign mul_b_ext = {16'h0000, mul_b};
    assign prod_d    = mul_a_ext * mul_b_ext;

    // Only bits [23:8] and [19:4] of the product are ever selected.
    logic unused_prod_bits;
    assign unused_prod_bits = ^{prod_q[31:24], prod_q[3:0]};

    // Next-state, operand select and writeback strobes.
    always_comb begin
        state_d   = state_q;
        snap_en   = 1'b0;
        mul_en    = 1'b0;
        mul_a     = 16'h0000;
        mul_b     = 16'h0000;
        wr_amp0   = 1'b0;
        wr_amp1   = 1'b0;
        wr_amp2   = 1'b0;
        wr_master = 1'b0;
        done_d    = 1'b0;
        overrun_d = CLKen && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (CLKen) begin
                    snap_en = 1'b1;
                    state_d = MUL0;
                end
            end
            MUL0: begin
                mul_en  = 1'b1;
                mul_a   = {voice0_q, 4'b0000};
                mul_b   = {8'h00, env0_q};
                state_d = MUL1;
            end
            MUL1: begin
                mul_en  = 1'b1;
                mul_a   = {voice1_q, 4'b0000};
                mul_b   = {8'h00, env1_q};
                wr_amp0 = 1'b1;
                state_d = MUL2;
            end
            MUL2: begin
                mul_en  = 1'b1;
                mul_a   = {voice2_q, 4'b0000};
                mul_b   = {8'h00, env2_q};
                wr_amp1 = 1'b1;
                state_d = MUL3;
            end
            MUL3: begin
                mul_en  = 1'b1;
                mul_a   = mix_q;
                mul_b   = {12'h000, vol_q};
                wr_amp2 = 1'b1;
                state_d = WB;
            end
            WB: begin
                wr_master = 1'b1;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and single-cycle status pulses.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= IDLE;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            overrun_q <= overrun_d;
        end
    end

    // Input snapshot taken when a frame is accepted; the only multiplier source.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            voice0_q <= 12'h000;
            voice1_q <= 12'h000;
            voice2_q <= 12'h000;
            env0_q   <= 8'h00;
            env1_q   <= 8'h00;
            env2_q   <= 8'h00;
            mix_q    <= 16'h0000;
            vol_q    <= 4'h0;
        end else if (snap_en) begin
            voice0_q <= VOICE0;
            voice1_q <= VOICE1;
            voice2_q <= VOICE2;
            env0_q   <= ENV0;
            env1_q   <= ENV1;
            env2_q   <= ENV2;
            mix_q    <= MIX;
            vol_q    <= VOL;
        end
    end

    // Shared product register, loaded once per multiply slot.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            prod_q <= 32'h0000_0000;
        end else if (mul_en) begin
            prod_q <= prod_d;
        end
    end

    // Result registers; each is written one cycle after its slot's multiply
    // and otherwise holds across frames.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            amp0_q   <= 16'h0000;
            amp1_q   <= 16'h0000;
            amp2_q   <= 16'h0000;
            master_q <= 16'h0000;
        end else begin
            if (wr_amp0)   amp0_q   <= prod_q[23:8];
            if (wr_amp1)   amp1_q   <= prod_q[23:8];
            if (wr_amp2)   amp2_q   <= prod_q[23:8];
            if (wr_master) master_q <= prod_q[19:4];
        end
    end

    assign AMP0    = amp0_q;
    assign AMP1    = amp1_q;
    assign AMP2    = amp2_q;
    assign MASTER  = master_q;
    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;
    assign OVERRUN = overrun_q;

endmodule

// File: tb/tb_mdac_sched.sv
// Bench for mdac_sched: table vectors, randomized frames against an
// arithmetic reference, and hand sequences for snapshot/overrun/reset.
module tb_mdac_sched;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        CLKen = 1'b0;
    logic [11:0] VOICE0, VOICE1, VOICE2;
    logic [7:0]  ENV0, ENV1, ENV2;
    logic [15:0] MIX;
    logic [3:0]  VOL;
    logic [15:0] AMP0, AMP1, AMP2, MASTER;
    logic        BUSY, DONE, OVERRUN;

    mdac_sched dut (
        .CLK(CLK), .RESETn(RESETn), .CLKen(CLKen),
        .VOICE0(VOICE0), .VOICE1(VOICE1), .VOICE2(VOICE2),
        .ENV0(ENV0), .ENV1(ENV1), .ENV2(ENV2),
        .MIX(MIX), .VOL(VOL),
        .AMP0(AMP0), .AMP1(AMP1), .AMP2(AMP2), .MASTER(MASTER),
        .BUSY(BUSY), .DONE(DONE), .OVERRUN(OVERRUN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [11:0] v0, v1, v2;
        logic [7:0]  e0, e1, e2;
        logic [15:0] mix;
        logic [3:0]  vol;
        logic [15:0] a0, a1, a2, m;
    } vec_t;

    int   checks = 0;
    int   failures = 0;
    vec_t cur;
    vec_t tbl [4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Reference: (voice * 16) * env, keep bits 23..8.
    function automatic logic [15:0] amp_ref(input logic [11:0] voice, input logic [7:0] env);
        int p;
        int e;
        p = $signed(voice);
        e = env;
        p = p * 16 * e;
        return p[23:8];
    endfunction

    // Reference: mix * vol, keep bits 19..4.
    function automatic logic [15:0] master_ref(input logic [15:0] mix, input logic [3:0] vol);
        int p;
        int g;
        p = $signed(mix);
        g = vol;
        p = p * g;
        return p[19:4];
    endfunction

    function automatic vec_t with_model(input vec_t v);
        vec_t r;
        r = v;
        r.a0 = amp_ref(v.v0, v.e0);
        r.a1 = amp_ref(v.v1, v.e1);
        r.a2 = amp_ref(v.v2, v.e2);
        r.m  = master_ref(v.mix, v.vol);
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.v0 = 12'($urandom); v.v1 = 12'($urandom); v.v2 = 12'($urandom);
        v.e0 = 8'($urandom);  v.e1 = 8'($urandom);  v.e2 = 8'($urandom);
        v.mix = 16'($urandom);
        v.vol = 4'($urandom);
        v.a0 = '0; v.a1 = '0; v.a2 = '0; v.m = '0;
        return with_model(v);
    endfunction

    task automatic apply(input vec_t v);
        cur = v;
        VOICE0 = v.v0; VOICE1 = v.v1; VOICE2 = v.v2;
        ENV0 = v.e0;   ENV1 = v.e1;   ENV2 = v.e2;
        MIX = v.mix;   VOL = v.vol;
    endtask

    task automatic check_outs(input string tag, input vec_t e);
        check({tag, "_amp0"},   AMP0,   e.a0);
        check({tag, "_amp1"},   AMP1,   e.a1);
        check({tag, "_amp2"},   AMP2,   e.a2);
        check({tag, "_master"}, MASTER, e.m);
    endtask

    // Called #1 after the edge that accepted CLKen (start of cycle 1).
    task automatic observe(input vec_t e, input bit ovr3, input bit restart6,
                           input bit mutate2, input string tag);
        vec_t m;
        for (int c = 1; c <= 6; c++) begin
            if (c == 2 && mutate2) begin
                m = rand_vec();
                m.v0 = ~cur.v0;
                m.vol = ~cur.vol;
                apply(with_model(m));
            end
            CLKen = (ovr3 && c == 3) || (restart6 && c == 6);
            @(negedge CLK);
            check($sformatf("%s_busy_c%0d", tag, c), BUSY, c <= 5);
            check($sformatf("%s_done_c%0d", tag, c), DONE, c == 6);
            check($sformatf("%s_ovr_c%0d", tag, c), OVERRUN, ovr3 && c == 4);
            if (c == 6) check_outs(tag, e);
            @(posedge CLK); #1;
        end
        CLKen = 1'b0;
    endtask

    task automatic frame(input vec_t v, input bit ovr3, input bit restart6,
                         input bit mutate2, input string tag);
        apply(v);
        CLKen = 1'b1;
        @(posedge CLK); #1;
        CLKen = 1'b0;
        observe(v, ovr3, restart6, mutate2, tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vec_t zero;

        tbl[0] = '{12'h7FF, 12'h800, 12'h123, 8'hFF, 8'hFF, 8'h00, 16'h4000, 4'hF,
                   16'h7F70, 16'h8080, 16'h0000, 16'h3C00};
        tbl[1] = '{12'h000, 12'h001, 12'h7FF, 8'hFF, 8'h01, 8'h80, 16'h8000, 4'hF,
                   16'h0000, 16'h0000, 16'h3FF8, 16'h8800};
        tbl[2] = '{12'h800, 12'h100, 12'hFFF, 8'h01, 8'h10, 8'hFF, 16'h7FFF, 4'h0,
                   16'hFF80, 16'h0100, 16'hFFF0, 16'h0000};
        tbl[3] = '{12'h001, 12'hFFF, 12'h400, 8'h10, 8'h01, 8'hFF, 16'hFFFF, 4'h1,
                   16'h0001, 16'hFFFF, 16'h3FC0, 16'hFFFF};

        zero = '{12'h0, 12'h0, 12'h0, 8'h0, 8'h0, 8'h0, 16'h0, 4'h0,
                 16'h0, 16'h0, 16'h0, 16'h0};
        apply(zero);
        RESETn = 1'b0;
        CLKen = 1'b0;

        // Reset state
        @(negedge CLK);
        check_outs("reset", zero);
        check("reset_busy", BUSY, 1'b0);
        check("reset_done", DONE, 1'b0);
        check("reset_ovr", OVERRUN, 1'b0);
        @(posedge CLK); #1;
        RESETn = 1'b1;
        @(posedge CLK); #1;

        // Table vectors, including the max-positive / max-negative / master cases
        for (int i = 0; i < 4; i++)
            frame(tbl[i], 1'b0, 1'b0, 1'b0, $sformatf("tbl%0d", i));

        // Randomized frames with random idle gaps
        for (int i = 0; i < 25; i++) begin
            frame(rand_vec(), 1'b0, 1'b0, 1'b0, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK); #1;
            end
        end

        // Inputs changed in cycle 2, CLKen in cycle 3 (overrun), CLKen in cycle 6
        v = rand_vec();
        frame(v, 1'b1, 1'b1, 1'b1, "snap_ovr");
        observe(cur, 1'b0, 1'b0, 1'b0, "chain");

        // Reset in cycle 3 of a frame after known nonzero outputs
        frame(tbl[0], 1'b0, 1'b0, 1'b0, "pre_rst");
        apply(rand_vec());
        CLKen = 1'b1;
        @(posedge CLK); #1;
        CLKen = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESETn = 1'b0;
        #1;
        check_outs("midrst", zero);
        check("midrst_busy", BUSY, 1'b0);
        check("midrst_done", DONE, 1'b0);
        check("midrst_ovr", OVERRUN, 1'b0);
        @(posedge CLK); #1;
        RESETn = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge CLK);
            check($sformatf("postrst_done_c%0d", c), DONE, 1'b0);
            check($sformatf("postrst_busy_c%0d", c), BUSY, 1'b0);
            check($sformatf("postrst_amp0_c%0d", c), AMP0, 16'h0000);
            check($sformatf("postrst_master_c%0d", c), MASTER, 16'h0000);
            @(posedge CLK); #1;
        end
        frame(rand_vec(), 1'b0, 1'b0, 1'b0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdac_sched.md
MDAC_SCHED -- requirements
Module: mdac_sched

Interface
REQ-001 Parameters: none.
REQ-002 CLK  in  1  master clock; all state on rising edge.
REQ-003 RESETn  in  1  reset; one clock, reset asynchronous active-low.
REQ-004 CLKen  in  1  1 MHz frame strobe; one-CLK pulse starts a frame.
REQ-005 VOICE0, VOICE1, VOICE2  in  12 each  signed voice samples.
REQ-006 ENV0, ENV1, ENV2  in  8 each  unsigned envelope levels.
REQ-007 MIX  in  16  signed post-filter mix for the master-volume stage.
REQ-008 VOL  in  4  unsigned master volume.
REQ-009 AMP0, AMP1, AMP2  out  16 each  signed enveloped voice results, registered.
REQ-010 MASTER  out  16  signed volume-scaled mix, registered.
REQ-011 BUSY  out  1  high while a frame is in progress.
REQ-012 DONE  out  1  one-cycle pulse when all four results of a frame are valid.
REQ-013 OVERRUN  out  1  one-cycle pulse when CLKen arrives while BUSY.

Function
REQ-014 The block SHALL time-share exactly one 16x16 signed-by-unsigned multiplier across four slots per frame, with its 32-bit product registered once.
REQ-015 The FSM SHALL have states IDLE, MUL0, MUL1, MUL2, MUL3 and WB.
REQ-016 In IDLE, CLKen=1 SHALL snapshot all VOICE*, ENV*, MIX and VOL and move to MUL0.
REQ-017 Transitions: MUL0 -> MUL1 -> MUL2 -> MUL3 -> WB -> IDLE, unconditionally, one cycle each.
REQ-018 Only the snapshot SHALL feed the multiplier, so input changes during a frame have no effect.
REQ-019 Slots 0-2 (MUL0-MUL2) SHALL compute {VOICEk,4'b0} (A, signed) times {8'b0,ENVk} (B, unsigned) and write product[23:8] to AMPk.
REQ-020 Slot 3 (MUL3) SHALL compute MIX (signed) times {12'b0,VOL} (unsigned) and write product[19:4] to MASTER.
REQ-021 Result writeback SHALL be one cycle after the slot's operands.
- AMP0 registered at end of MUL1.
- AMP1 registered at end of MUL2.
- AMP2 registered at end of MUL3.
- MASTER registered at end of WB.
REQ-022 Timing, with the CLKen-accepting cycle numbered 0:
- BUSY high in cycles 1-5.
- DONE high in cycle 6 only, with all four outputs already holding the new frame.
REQ-023 In cycle 6 the FSM is in IDLE, so a CLKen in cycle 6 SHALL start a new frame; the minimum frame period is 6 cycles.
REQ-024 CLKen while BUSY SHALL be ignored and SHALL pulse OVERRUN in the following cycle; the frame in progress is unaffected.
REQ-025 Outputs SHALL hold their last values between frames; slots not yet written in a frame keep their previous values.
REQ-026 No saturation is applied: the bit slices are taken directly, and the full operand ranges cannot overflow them.

Reset
REQ-027 RESETn=0 SHALL asynchronously force the following; the multiplier product register and snapshot SHALL clear to 0:
- FSM to IDLE.
- AMP0-2, MASTER = 0.
- BUSY, DONE, OVERRUN = 0.
REQ-028 A reset during a frame SHALL abandon that frame with no partial writeback after release and no DONE.
REQ-029 After RESETn deasserts, the first CLKen SHALL start a clean frame.

Verification
REQ-030 Max positive: VOICE0=0x7FF, ENV0=0xFF, CLKen at cycle 0 -> AMP0=0x7F70, DONE at cycle 6, BUSY cycles 1-5.
REQ-031 Max negative: VOICE1=0x800, ENV1=0xFF -> AMP1=0x8080. VOICE2=0x123, ENV2=0x00 -> AMP2=0x0000.
REQ-032 Master stage:
- MIX=0x4000, VOL=0xF -> MASTER=0x3C00.
- MIX=0x8000, VOL=0xF -> MASTER=0x8800.
- VOL=0 -> MASTER=0x0000.
REQ-033 Snapshot and overrun:
- Change VOICE0 and VOL in cycle 2 -> results use the cycle-0 values.
- CLKen in cycle 3 -> OVERRUN=1 in cycle 4, DONE still in cycle 6.
- CLKen in cycle 6 -> DONE in cycle 12.
REQ-034 Reset mid-frame: RESETn=0 in cycle 3 -> all outputs 0 immediately, and no DONE appears. Next CLKen -> normal frame with DONE 6 cycles later.
